// File: rtl/rv_sysmon_pkg.sv
// Shared definitions for the rv_sysmon_mc system-monitor bridge: register map,
// CTRL/STATUS bit positions, fan FSM states and bus helper types.
package rv_sysmon_pkg;

  typedef logic [3:0]  u4_t;
  typedef logic [5:0]  u6_t;
  typedef logic [15:0] u16_t;
  typedef logic [31:0] u32_t;

  localparam int REG_CTRL        = 0;
  localparam int REG_STATUS      = 1;
  localparam int REG_THRESH      = 2;
  localparam int REG_VALUE_BASE  = 4;
  localparam int REG_MINMAX_BASE = 20;

  localparam int CTRL_AUTO_BIT      = 16;
  localparam int CTRL_CLR_MM_BIT    = 17;
  localparam int CTRL_CLR_ALARM_BIT = 18;

  localparam int STATUS_STATE_BIT = 8;
  localparam int STATUS_ALARM_BIT = 9;

  typedef enum logic [0:0] {
    FAN_LOW  = 1'b0,
    FAN_HIGH = 1'b1
  } fan_state_t;

  // Replace the byte lanes of cur selected by be with the matching lanes of wdata.
  function automatic u32_t byte_merge(input u32_t cur, input u32_t wdata, input u4_t be);
    u32_t res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = wdata[8*b +: 8];
      end else begin
        res[8*b +: 8] = cur[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rv_pwm_gen.sv
// Fan PWM generator: free-running prescaler gates a PWM_W-bit period counter,
// and the registered output is high while the counter is below the duty.
module rv_pwm_gen
  import rv_sysmon_pkg::*;
#(
  parameter int PWM_W = 8,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             xreset,
  input  logic [PWM_W-1:0] duty,
  output logic             fan_out
);

  logic [PRE_W-1:0] pre_r;
  logic [PWM_W-1:0] cnt_r;

  // Prescaler, period counter and registered fan drive.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      pre_r   <= '0;
      cnt_r   <= '0;
      fan_out <= 1'b0;
    end else begin
      pre_r <= pre_r + 1'b1;
      if (pre_r == '0) begin
        cnt_r <= cnt_r + 1'b1;
      end
      fan_out <= (cnt_r < duty);
    end
  end

endmodule

// File: rtl/rv_sysmon_mc.sv
// Multi-channel sysmon bridge: captures the ADC sample stream per channel with
// min/max tracking and drives the fan PWM manually or by temperature hysteresis.
module rv_sysmon_mc
  import rv_sysmon_pkg::*;
#(
  parameter int NCH     = 8,
  parameter int TEMP_CH = 0,
  parameter int PWM_W   = 8,
  parameter int PRE_W   = 16,
  parameter int ADR_W   = 7
) (
  input  logic             clk,
  input  logic             xreset,
  input  logic [ADR_W-1:0] adr,
  input  logic             cs,
  input  logic             rdy,
  input  logic [3:0]       we,
  input  logic             re,
  input  logic [31:0]      dw,
  output logic [31:0]      dr,
  input  logic             eoc_in,
  input  logic [5:0]       channel_in,
  input  logic [15:0]      adc_in,
  output logic             fan_out,
  output logic             alarm_out
);

  logic [PWM_W-1:0] duty_r;
  logic             auto_r;
  u32_t             thresh_r;
  fan_state_t       state_r;
  fan_state_t       state_nxt_s;
  u16_t             value_r [NCH];
  u16_t             min_r   [NCH];
  u16_t             max_r   [NCH];
  logic             re1_r;
  logic [ADR_W-3:0] adr1_r;

  u32_t             widx_s;
  u32_t             ridx_s;
  logic             wr_s;
  logic             wr_ctrl_s;
  logic             wr_thresh_s;
  logic             clr_mm_s;
  logic             clr_alarm_s;
  u32_t             ctrl_cur_s;
  u32_t             ctrl_new_s;
  u32_t             status_s;
  logic [NCH-1:0]   ch_hit_s;
  logic             temp_hit_s;
  logic             alarm_set_s;
  logic [PWM_W-1:0] eff_duty_s;
  logic             unused_s;

  assign widx_s      = 32'(adr[ADR_W-1:2]);
  assign ridx_s      = 32'(adr1_r);
  assign wr_s        = cs && rdy;
  assign wr_ctrl_s   = wr_s && (widx_s == 32'(REG_CTRL));
  assign wr_thresh_s = wr_s && (widx_s == 32'(REG_THRESH));
  assign clr_mm_s    = wr_ctrl_s && we[2] && dw[CTRL_CLR_MM_BIT];
  assign clr_alarm_s = wr_ctrl_s && we[2] && dw[CTRL_CLR_ALARM_BIT];
  assign temp_hit_s  = eoc_in && (channel_in == 6'(TEMP_CH));
  assign alarm_set_s = (state_r == FAN_LOW) && (state_nxt_s == FAN_HIGH);
  assign eff_duty_s  = (auto_r && (state_r == FAN_HIGH)) ? {PWM_W{1'b1}} : duty_r;
  assign ctrl_new_s  = byte_merge(ctrl_cur_s, dw, we);
  assign unused_s    = ^{adr[1:0], ctrl_new_s};

  // Current CTRL image and STATUS word assembled from their fields.
  always_comb begin
    ctrl_cur_s                = 32'h0000_0000;
    ctrl_cur_s[PWM_W-1:0]     = duty_r;
    ctrl_cur_s[CTRL_AUTO_BIT] = auto_r;
    status_s                   = 32'h0000_0000;
    status_s[PWM_W-1:0]        = eff_duty_s;
    status_s[STATUS_STATE_BIT] = (state_r == FAN_HIGH);
    status_s[STATUS_ALARM_BIT] = alarm_out;
  end

  // Per-channel hit decode; channels at or above NCH never match.
  always_comb begin
    ch_hit_s = '0;
    for (int n = 0; n < NCH; n++) begin
      ch_hit_s[n] = eoc_in && (channel_in == 6'(n));
    end
  end

  // CTRL and THRESH register writes with byte lanes.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      duty_r   <= '0;
      auto_r   <= 1'b0;
      thresh_r <= 32'h0000_0000;
    end else begin
      if (wr_ctrl_s) begin
        duty_r <= ctrl_new_s[PWM_W-1:0];
        auto_r <= ctrl_new_s[CTRL_AUTO_BIT];
      end
      if (wr_thresh_s) begin
        thresh_r <= byte_merge(thresh_r, dw, we);
      end
    end
  end

  // Sample capture; a min/max clear overrides a coincident sample.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      for (int n = 0; n < NCH; n++) begin
        value_r[n] <= 16'h0000;
        min_r[n]   <= 16'hFFFF;
        max_r[n]   <= 16'h0000;
      end
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (ch_hit_s[n]) begin
          value_r[n] <= adc_in;
        end
        if (clr_mm_s) begin
          min_r[n] <= 16'hFFFF;
          max_r[n] <= 16'h0000;
        end else if (ch_hit_s[n]) begin
          if (adc_in < min_r[n]) min_r[n] <= adc_in;
          if (adc_in > max_r[n]) max_r[n] <= adc_in;
        end
      end
    end
  end

  // Hysteresis decision: the high threshold is tested first so T_LO > T_HI stays well defined.
  always_comb begin
    state_nxt_s = state_r;
    if (temp_hit_s) begin
      if (adc_in >= thresh_r[31:16]) begin
        state_nxt_s = FAN_HIGH;
      end else if (adc_in < thresh_r[15:0]) begin
        state_nxt_s = FAN_LOW;
      end else begin
        state_nxt_s = state_r;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Fan FSM state and sticky alarm; a new rising transition beats a clear.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      state_r   <= FAN_LOW;
      alarm_out <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (alarm_set_s) begin
        alarm_out <= 1'b1;
      end else if (clr_alarm_s) begin
        alarm_out <= 1'b0;
      end
    end
  end

  // Read request pipeline, advanced only while the bus is ready.
  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      re1_r  <= 1'b0;
      adr1_r <= '0;
    end else if (rdy) begin
      re1_r  <= cs && re;
      adr1_r <= adr[ADR_W-1:2];
    end
  end

  // Read data mux from the latched request.
  always_comb begin
    dr = 32'h0000_0000;
    if (re1_r) begin
      case (ridx_s)
        32'(REG_CTRL):   dr = ctrl_cur_s;
        32'(REG_STATUS): dr = status_s;
        32'(REG_THRESH): dr = thresh_r;
        default: begin
          for (int n = 0; n < NCH; n++) begin
            dr = (ridx_s == 32'(REG_VALUE_BASE + n))  ? {16'h0000, value_r[n]} : dr;
            dr = (ridx_s == 32'(REG_MINMAX_BASE + n)) ? {max_r[n], min_r[n]}   : dr;
          end
        end
      endcase
    end else begin
      dr = 32'h0000_0000;
    end
  end

  rv_pwm_gen #(
    .PWM_W(PWM_W),
    .PRE_W(PRE_W)
  ) u_pwm (
    .clk    (clk),
    .xreset (xreset),
    .duty   (eff_duty_s),
    .fan_out(fan_out)
  );

endmodule

// File: tb/tb_rv_sysmon_mc.sv
// Directed bench for rv_sysmon_mc: a default-width instance for the register map
// and hysteresis, plus a short-prescaler 4-bit instance for PWM timing.
module tb_rv_sysmon_mc;

  logic        clk;
  logic        xreset;
  logic [6:0]  adr;
  logic        cs;
  logic        rdy;
  logic [3:0]  we;
  logic        re;
  logic [31:0] dw;
  logic        eoc_in;
  logic [5:0]  channel_in;
  logic [15:0] adc_in;
  logic [31:0] dr_main, dr_pwm;
  logic        fan_main, fan_pwm;
  logic        alarm_main, alarm_pwm;

  int checks;
  int failures;

  localparam logic [6:0] A_CTRL    = 7'h00;
  localparam logic [6:0] A_STATUS  = 7'h04;
  localparam logic [6:0] A_THRESH  = 7'h08;
  localparam logic [6:0] A_VALUE0  = 7'h10;
  localparam logic [6:0] A_VALUE1  = 7'h14;
  localparam logic [6:0] A_MINMAX1 = 7'h54;

  rv_sysmon_mc dut (
    .clk(clk), .xreset(xreset), .adr(adr), .cs(cs), .rdy(rdy), .we(we), .re(re),
    .dw(dw), .dr(dr_main), .eoc_in(eoc_in), .channel_in(channel_in), .adc_in(adc_in),
    .fan_out(fan_main), .alarm_out(alarm_main)
  );

  rv_sysmon_mc #(.PWM_W(4), .PRE_W(2)) dut_pwm (
    .clk(clk), .xreset(xreset), .adr(adr), .cs(cs), .rdy(rdy), .we(we), .re(re),
    .dw(dw), .dr(dr_pwm), .eoc_in(eoc_in), .channel_in(channel_in), .adc_in(adc_in),
    .fan_out(fan_pwm), .alarm_out(alarm_pwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [6:0] a, input logic [3:0] w, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; rdy = 1'b1; adr = a; we = w; dw = d;
    @(negedge clk);
    cs = 1'b0; we = 4'h0; dw = 32'h0;
  endtask

  task automatic bus_read(input logic [6:0] a, output logic [31:0] d, output logic [31:0] d2);
    @(negedge clk);
    cs = 1'b1; rdy = 1'b1; re = 1'b1; adr = a;
    @(negedge clk);
    cs = 1'b0; re = 1'b0;
    d = dr_main; d2 = dr_pwm;
  endtask

  task automatic sample(input logic [5:0] ch, input logic [15:0] v);
    @(negedge clk);
    eoc_in = 1'b1; channel_in = ch; adc_in = v;
    @(negedge clk);
    eoc_in = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d, d2;
    repeat (3) @(negedge clk);
    checks++;
    if (dr_main !== 32'h0 || fan_main !== 1'b0 || alarm_main !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: dr=%h fan=%b alarm=%b, required 0/0/0", dr_main, fan_main, alarm_main);
    end
    xreset = 1'b1;
    bus_read(A_CTRL, d, d2);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_ctrl: got %h required 00000000", d); end
    bus_read(A_MINMAX1, d, d2);
    checks++;
    if (d !== 32'h0000_FFFF) begin failures++; $display("FAIL reset_minmax: got %h required 0000ffff", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d, d2;
    bus_write(A_CTRL, 4'hF, 32'h0001_0040);
    bus_write(A_THRESH, 4'hF, 32'h0900_0800);
    bus_read(A_CTRL, d, d2);
    checks++;
    if (d !== 32'h0001_0040) begin failures++; $display("FAIL ctrl_rw: got %h required 00010040", d); end
    bus_read(A_THRESH, d, d2);
    checks++;
    if (d !== 32'h0900_0800) begin failures++; $display("FAIL thresh_rw: got %h required 09000800", d); end
    @(negedge clk);
    cs = 1'b1; re = 1'b1; adr = A_THRESH; rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (dr_main !== 32'h0) begin failures++; $display("FAIL read_stall: got %h required 00000000", dr_main); end
    rdy = 1'b1;
    @(negedge clk);
    cs = 1'b0; re = 1'b0;
    checks++;
    if (dr_main !== 32'h0900_0800) begin failures++; $display("FAIL read_after_rdy: got %h required 09000800", dr_main); end
  endtask

  task automatic test_capture();
    logic [31:0] d, d2;
    sample(6'd1, 16'h1234);
    sample(6'd1, 16'h1000);
    sample(6'd1, 16'h2000);
    bus_read(A_VALUE1, d, d2);
    checks++;
    if (d !== 32'h0000_2000) begin failures++; $display("FAIL value1: got %h required 00002000", d); end
    bus_read(A_MINMAX1, d, d2);
    checks++;
    if (d !== 32'h2000_1000) begin failures++; $display("FAIL minmax1: got %h required 20001000", d); end
    sample(6'd8, 16'h0001);
    bus_read(A_VALUE0, d, d2);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL ch_out_of_range_value0: got %h required 00000000", d); end
    bus_read(A_MINMAX1, d, d2);
    checks++;
    if (d !== 32'h2000_1000) begin failures++; $display("FAIL ch_out_of_range_minmax1: got %h required 20001000", d); end
  endtask

  task automatic test_clear_minmax();
    logic [31:0] d, d2;
    @(negedge clk);
    cs = 1'b1; rdy = 1'b1; adr = A_CTRL; we = 4'b0100; dw = 32'h0003_0000;
    eoc_in = 1'b1; channel_in = 6'd1; adc_in = 16'h0500;
    @(negedge clk);
    cs = 1'b0; we = 4'h0; dw = 32'h0; eoc_in = 1'b0;
    bus_read(A_MINMAX1, d, d2);
    checks++;
    if (d !== 32'h0000_FFFF) begin failures++; $display("FAIL clear_minmax: got %h required 0000ffff", d); end
    bus_read(A_VALUE1, d, d2);
    checks++;
    if (d !== 32'h0000_0500) begin failures++; $display("FAIL clear_value: got %h required 00000500", d); end
  endtask

  task automatic test_hysteresis();
    logic [31:0] d, d2;
    sample(6'd0, 16'h0850);
    bus_read(A_STATUS, d, d2);
    checks++;
    if (d !== 32'h0000_0040) begin failures++; $display("FAIL hyst_mid_low: got %h required 00000040", d); end
    sample(6'd0, 16'h0900);
    bus_read(A_STATUS, d, d2);
    checks++;
    if (d !== 32'h0000_03FF || alarm_main !== 1'b1) begin
      failures++; $display("FAIL hyst_to_high: status=%h alarm=%b required 000003ff/1", d, alarm_main);
    end
    sample(6'd0, 16'h0850);
    bus_read(A_STATUS, d, d2);
    checks++;
    if (d !== 32'h0000_03FF) begin failures++; $display("FAIL hyst_hold_high: got %h required 000003ff", d); end
    sample(6'd0, 16'h07FF);
    bus_read(A_STATUS, d, d2);
    checks++;
    if (d !== 32'h0000_0240 || alarm_main !== 1'b1) begin
      failures++; $display("FAIL hyst_to_low: status=%h alarm=%b required 00000240/1", d, alarm_main);
    end
    bus_write(A_CTRL, 4'b0100, 32'h0005_0000);
    bus_read(A_STATUS, d, d2);
    checks++;
    if (d !== 32'h0000_0040 || alarm_main !== 1'b0) begin
      failures++; $display("FAIL alarm_clear: status=%h alarm=%b required 00000040/0", d, alarm_main);
    end
  endtask

  task automatic pwm_case(input logic [3:0] duty, input int expect_hi);
    int hi;
    bus_write(A_CTRL, 4'hF, {28'h0, duty});
    repeat (4) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 64; i++) begin
      if (fan_pwm === 1'b1) hi++;
      @(negedge clk);
    end
    checks++;
    if (hi !== expect_hi) begin
      failures++; $display("FAIL pwm_duty_%0d: high clocks %0d of 64, required %0d", duty, hi, expect_hi);
    end
  endtask

  task automatic test_pwm();
    logic [31:0] d, d2;
    pwm_case(4'd0, 0);
    pwm_case(4'd4, 16);
    pwm_case(4'd15, 60);
    bus_read(A_STATUS, d, d2);
    checks++;
    if (d2 !== 32'h0000_000F) begin failures++; $display("FAIL pwm_status: got %h required 0000000f", d2); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, d2;
    bus_write(A_CTRL, 4'hF, 32'h0001_0040);
    sample(6'd0, 16'h0950);
    sample(6'd1, 16'h0300);
    @(negedge clk);
    cs = 1'b1; re = 1'b1; rdy = 1'b1; adr = A_STATUS;
    @(negedge clk);
    cs = 1'b0; re = 1'b0;
    checks++;
    if (dr_main !== 32'h0000_03FF) begin failures++; $display("FAIL pre_reset_status: got %h required 000003ff", dr_main); end
    xreset = 1'b0;
    #1;
    checks++;
    if (dr_main !== 32'h0 || fan_main !== 1'b0 || alarm_main !== 1'b0 || fan_pwm !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs: dr=%h fan=%b alarm=%b fan_pwm=%b required 0/0/0/0", dr_main, fan_main, alarm_main, fan_pwm);
    end
    @(negedge clk);
    xreset = 1'b1;
    bus_read(A_MINMAX1, d, d2);
    checks++;
    if (d !== 32'h0000_FFFF) begin failures++; $display("FAIL post_reset_minmax: got %h required 0000ffff", d); end
    bus_read(A_STATUS, d, d2);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL post_reset_status: got %h required 00000000", d); end
  endtask

  initial begin
    checks = 0; failures = 0;
    xreset = 1'b0; adr = 7'h0; cs = 1'b0; rdy = 1'b1; we = 4'h0; re = 1'b0; dw = 32'h0;
    eoc_in = 1'b0; channel_in = 6'h0; adc_in = 16'h0;
    test_reset();
    test_regs();
    test_capture();
    test_clear_minmax();
    test_hysteresis();
    test_pwm();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
